pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline latches (FD, DE, EM, MW).
- Each cycle it decides, per latch, whether to advance, hold or inject a bubble, and whether the PC advances.
- Handles cache-miss waits, load-use hazards, taken branches and jumps, and the halt drain.
- Sits beside the datapath; consumes hit signals from the cache interface and hazard fields from the DE/EM latch outputs.

Parameters:
- DRAIN_CYCLES, 2, cycles from halt seen in EM until halted asserts (halt moves EM->MW->WB).
- CNT_W, 32, perf counter width; used only with the optional feature.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access in MEM completed this cycle.
- dREN_M  in  1  EM_out.dcuREN.
- dWEN_M  in  1  EM_out.dcuWEN.
- halt_M  in  1  EM_out.halt.
- load_E  in  1  DE_out.dcuREN, i.e. a load is in EX.
- rt_E  in  5  DE_out.rt, destination register of the load.
- rs_D, rt_D  in  5 each  source registers decoded from FD_out.instr.
- branch_E  in  1  branch resolved taken in EX.
- jump_D  in  1  J/JAL/JR decoded in ID.
- pc_en  out  1  PC register update enable.
- FD_en, DE_en, EM_en, MW_en  out  1 each  latch load enables.
- FD_flush, DE_flush, EM_flush  out  1 each  load bubble (all zeros) instead of _in; only valid with the matching _en=1.
- icuREN  out  1  instruction read request.
- halted  out  1  processor halted.

Behaviour:
- States: RUN, MEMWAIT, DRAIN, HALT. State and drain counter are registered; other outputs are combinational from state and inputs.
- Reset (nRST=0): state=RUN; counter=0; all _en=0; all _flush=0; pc_en=0; icuREN=0; halted=0.
- Reset mid-operation returns to RUN immediately; no pending stall is remembered.
- RUN priority, highest first:
  1. Memory wait: (dREN_M|dWEN_M) & !dhit -> all _en=0, pc_en=0; next state MEMWAIT.
  2. Branch: branch_E -> FD_flush=1, DE_flush=1, all _en=1, pc_en=1.
  3. Load-use: load_E & rt_E!=0 & (rt_E==rs_D | rt_E==rt_D) -> pc_en=0, FD_en=0, DE_en=1 with DE_flush=1, EM_en=MW_en=1.
  4. Jump: jump_D -> FD_flush=1, all _en=1, pc_en=1.
  5. Fetch miss: !ihit -> pc_en=0, FD_en=1 with FD_flush=1, remaining _en=1.
  6. Otherwise all _en=1, pc_en=1, no flush.
- icuREN=1 in RUN and MEMWAIT.
- MEMWAIT: all _en=0, pc_en=0 until dhit. On dhit, exit to RUN and apply the RUN rules in the same cycle with the memory-wait term masked, so the latches advance on the dhit cycle.
- A branch or hazard coincident with a memory wait is not lost: DE is frozen, so it is re-evaluated on exit.
- Halt: halt_M while in RUN (and not memory-waiting) -> next state DRAIN, counter=DRAIN_CYCLES-1.
- DRAIN: pc_en=0, FD_flush=DE_flush=1 with FD_en=DE_en=1, EM_en=MW_en=1, icuREN=0. Counter decrements each cycle; at 0 go to HALT.
- HALT: all _en=0, pc_en=0, icuREN=0, halted=1. The only exit is reset.
- Register $0 never creates a load-use stall.
- ihit is ignored outside RUN.

Optional Feature:
- PIPELINE_PERF_EN defined:
  - Adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - stall_cnt increments on every cycle in RUN or MEMWAIT with pc_en=0.
  - flush_cnt increments once per cycle in RUN in which any flush is asserted.
  - Both counters saturate at all ones, clear on reset, and freeze in HALT.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- pipeline_regs_pkg gains a sequencer state enum (RUN, MEMWAIT, DRAIN, HALT) as a 2-bit typedef.
- The bubble value for each latch is a zero constant of FD_t/DE_t/EM_t.
- regbits_t comes from cpu_types_pkg.
- One combinational sub-module, hazard_detect: the load-use comparator, inputs load_E, rt_E, rs_D, rt_D; output luse.

Test Plan:
- Reset then release with ihit=1 -> cycle 1: all _en=1, pc_en=1, no flushes, halted=0.
- lw into rt_E=5 in EX, FD instruction has rs_D=5 -> one cycle with pc_en=0, FD_en=0, DE_flush=1; next cycle normal. Repeat with rt_E=0 -> no stall.
- dREN_M=1, dhit low for 3 cycles -> 3 cycles of all _en=0; on the 4th cycle (dhit=1) all _en=1.
- branch_E=1 coincident with a dhit miss -> hold; on the dhit cycle FD_flush=DE_flush=1, pc_en=1.
- halt_M=1 -> pc_en=0 and flushes for 2 cycles, then halted=1, icuREN=0. Asserting nRST low in HALT clears halted asynchronously.
- With PIPELINE_PERF_EN: 2 load-use stalls plus 1 branch -> stall_cnt=2, flush_cnt=3.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// ============================================================================
// Module  : pipeline_sequencer_pkg
// Purpose : Shared types and constants for the pipeline stall/flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_sequencer_pkg;

    // Register-file index type.
    typedef logic [4:0] regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

    // Sequencer state encoding.
    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_RUN     = 2'd0;
    localparam seq_state_t ST_MEMWAIT = 2'd1;
    localparam seq_state_t ST_DRAIN   = 2'd2;
    localparam seq_state_t ST_HALT    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pipeline_sequencer_if.sv
// ============================================================================
// Module  : pipeline_sequencer_if
// Purpose : Hazard inputs and latch-control outputs between sequencer and datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_sequencer_if;
    import pipeline_sequencer_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     dREN_M;
    logic     dWEN_M;
    logic     halt_M;
    logic     load_E;
    regbits_t rt_E;
    regbits_t rs_D;
    regbits_t rt_D;
    logic     branch_E;
    logic     jump_D;

    logic     pc_en;
    logic     FD_en;
    logic     DE_en;
    logic     EM_en;
    logic     MW_en;
    logic     FD_flush;
    logic     DE_flush;
    logic     EM_flush;
    logic     icuREN;
    logic     halted;

    // Sequencer side.
    modport master (
        input  ihit, dhit, dREN_M, dWEN_M, halt_M, load_E, rt_E, rs_D, rt_D,
               branch_E, jump_D,
        output pc_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush, EM_flush,
               icuREN, halted
    );

    // Datapath side.
    modport slave (
        output ihit, dhit, dREN_M, dWEN_M, halt_M, load_E, rt_E, rs_D, rt_D,
               branch_E, jump_D,
        input  pc_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush, EM_flush,
               icuREN, halted
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_sequencer_hazard_detect.sv
// ============================================================================
// Module  : pipeline_sequencer_hazard_detect
// Purpose : Load-use comparator; $0 never produces a hazard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer_hazard_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic     load_E,
    input  regbits_t rt_E,
    input  regbits_t rs_D,
    input  regbits_t rt_D,
    output logic     luse
);

    assign luse = load_E && (rt_E != REG_ZERO) && ((rt_E == rs_D) || (rt_E == rt_D));

endmodule

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module  : pipeline_sequencer
// Purpose : Stall/flush/advance controller for the FD/DE/EM/MW pipeline latches.
//           Optional perf counters enabled by macro PIPELINE_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
`ifdef PIPELINE_PERF_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic                CLK,
    input  logic                nRST,
    pipeline_sequencer_if.master bus
`ifdef PIPELINE_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
`endif
);

    localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] c_drain_init = DCW'(DRAIN_CYCLES - 1);

    seq_state_t     r_state;
    seq_state_t     w_state_nxt;
    logic [DCW-1:0] r_cnt;
    logic [DCW-1:0] w_cnt_nxt;

    logic w_luse;
    logic w_mem_wait;
    logic w_run_eval;
    logic w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en;
    logic w_fd_flush, w_de_flush;
    logic w_icu_ren, w_halted;

    pipeline_sequencer_hazard_detect u_hazard (
        .load_E (bus.load_E),
        .rt_E   (bus.rt_E),
        .rs_D   (bus.rs_D),
        .rt_D   (bus.rt_D),
        .luse   (w_luse)
    );

    assign w_mem_wait = (bus.dREN_M || bus.dWEN_M) && !bus.dhit;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_run_eval  = 1'b0;
        w_pc_en     = 1'b0;
        w_fd_en     = 1'b0;
        w_de_en     = 1'b0;
        w_em_en     = 1'b0;
        w_mw_en     = 1'b0;
        w_fd_flush  = 1'b0;
        w_de_flush  = 1'b0;
        w_icu_ren   = 1'b0;
        w_halted    = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_icu_ren = 1'b1;
                if (w_mem_wait) begin
                    w_state_nxt = ST_MEMWAIT;
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                // The dhit cycle is treated as a RUN cycle so the latches advance on it.
                w_icu_ren = 1'b1;
                if (bus.dhit) begin
                    w_state_nxt = ST_RUN;
                    w_run_eval  = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_fd_en    = 1'b1;
                w_de_en    = 1'b1;
                w_em_en    = 1'b1;
                w_mw_en    = 1'b1;
                w_fd_flush = 1'b1;
                w_de_flush = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_halted = 1'b1;
            end
        endcase

        if (w_run_eval) begin
            w_fd_en = 1'b1;
            w_de_en = 1'b1;
            w_em_en = 1'b1;
            w_mw_en = 1'b1;
            w_pc_en = 1'b1;
            if (bus.branch_E) begin
                w_fd_flush = 1'b1;
                w_de_flush = 1'b1;
            end else if (w_luse) begin
                w_pc_en    = 1'b0;
                w_fd_en    = 1'b0;
                w_de_flush = 1'b1;
            end else if (bus.jump_D) begin
                w_fd_flush = 1'b1;
            end else if (!bus.ihit) begin
                w_pc_en    = 1'b0;
                w_fd_flush = 1'b1;
            end

            if (bus.halt_M) begin
                w_state_nxt = ST_DRAIN;
                w_cnt_nxt   = c_drain_init;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign bus.pc_en    = nRST && w_pc_en;
    assign bus.FD_en    = nRST && w_fd_en;
    assign bus.DE_en    = nRST && w_de_en;
    assign bus.EM_en    = nRST && w_em_en;
    assign bus.MW_en    = nRST && w_mw_en;
    assign bus.FD_flush = nRST && w_fd_flush;
    assign bus.DE_flush = nRST && w_de_flush;
    assign bus.EM_flush = 1'b0;
    assign bus.icuREN   = nRST && w_icu_ren;
    assign bus.halted   = nRST && w_halted;

`ifdef PIPELINE_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = ((r_state == ST_RUN) || (r_state == ST_MEMWAIT)) && !w_pc_en;
    // Flushes outside RUN-rule evaluation belong to the halt drain and are not counted.
    assign w_flush_inc = w_run_eval && (w_fd_flush || w_de_flush);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (w_flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module  : tb_pipeline_sequencer
// Purpose : Directed scoreboard bench for pipeline_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    // {pc_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush, EM_flush, icuREN, halted}
    localparam logic [9:0] c_rst   = 10'b0_0000_000_0_0;
    localparam logic [9:0] c_norm  = 10'b1_1111_000_1_0;
    localparam logic [9:0] c_hold  = 10'b0_0000_000_1_0;
    localparam logic [9:0] c_br    = 10'b1_1111_110_1_0;
    localparam logic [9:0] c_lu    = 10'b0_0111_010_1_0;
    localparam logic [9:0] c_jmp   = 10'b1_1111_100_1_0;
    localparam logic [9:0] c_miss  = 10'b0_1111_100_1_0;
    localparam logic [9:0] c_drain = 10'b0_1111_110_0_0;
    localparam logic [9:0] c_halt  = 10'b0_0000_000_0_1;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_err;
    sb_t  sb[$];

    pipeline_sequencer_if bus ();

`ifdef PIPELINE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipeline_sequencer #(
        .DRAIN_CYCLES (2)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.master)
`ifdef PIPELINE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bus.ihit     = 1'b1;
        bus.dhit     = 1'b0;
        bus.dREN_M   = 1'b0;
        bus.dWEN_M   = 1'b0;
        bus.halt_M   = 1'b0;
        bus.load_E   = 1'b0;
        bus.rt_E     = 5'd0;
        bus.rs_D     = 5'd0;
        bus.rt_D     = 5'd0;
        bus.branch_E = 1'b0;
        bus.jump_D   = 1'b0;
    endtask

    task automatic push(input string tag, input logic [9:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_out();
        sb_t        e;
        logic [9:0] obs;
        obs = {bus.pc_en, bus.FD_en, bus.DE_en, bus.EM_en, bus.MW_en,
               bus.FD_flush, bus.DE_flush, bus.EM_flush, bus.icuREN, bus.halted};
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed=%b expected=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    // Inputs are already driven; sample mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [9:0] exp);
        push(tag, exp);
        @(negedge CLK);
        check_out();
        @(posedge CLK);
        #1;
    endtask

    // Pulse reset between clock edges, checking quiet outputs and state afterwards.
    task automatic async_reset(input string tag);
        nRST = 1'b0;
        push({tag, "_asserted"}, c_rst);
        #1;
        check_out();
        #1;
        nRST = 1'b1;
        idle();
        push({tag, "_released"}, c_norm);
        #1;
        check_out();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        nRST     = 1'b0;
        idle();
        @(posedge CLK);
        #1;
        step("reset_state", c_rst);

        nRST = 1'b1;
        step("first_cycle", c_norm);

        bus.load_E = 1'b1; bus.rt_E = 5'd5; bus.rs_D = 5'd5;
        step("luse_rs", c_lu);
        idle();
        step("after_luse", c_norm);
        bus.load_E = 1'b1; bus.rt_E = 5'd0; bus.rs_D = 5'd0;
        step("luse_r0", c_norm);
        bus.rt_E = 5'd7; bus.rt_D = 5'd7;
        step("luse_rt", c_lu);
        bus.rt_D = 5'd8;
        step("load_nodep", c_norm);
        idle();

        bus.jump_D = 1'b1;
        step("jump", c_jmp);
        idle(); bus.ihit = 1'b0;
        step("fetch_miss", c_miss);
        idle(); bus.branch_E = 1'b1; bus.load_E = 1'b1; bus.rt_E = 5'd3; bus.rs_D = 5'd3;
        step("branch_over_luse", c_br);
        idle(); bus.jump_D = 1'b1; bus.ihit = 1'b0;
        step("jump_over_miss", c_jmp);
        idle();

        bus.dREN_M = 1'b1; bus.dhit = 1'b0;
        step("mw_1", c_hold);
        step("mw_2", c_hold);
        bus.ihit = 1'b0;
        step("mw_3_ihit_ignored", c_hold);
        bus.ihit = 1'b1; bus.dhit = 1'b1;
        step("mw_exit", c_norm);
        idle();
        step("mw_after", c_norm);

        bus.dWEN_M = 1'b1; bus.dhit = 1'b0; bus.branch_E = 1'b1;
        step("br_mw_hold", c_hold);
        bus.dhit = 1'b1;
        step("br_mw_exit", c_br);
        idle(); bus.dWEN_M = 1'b1; bus.dhit = 1'b1;
        step("store_hit", c_norm);
        idle();

        bus.halt_M = 1'b1;
        step("halt_seen", c_norm);
        idle();
        step("drain_1", c_drain);
        step("drain_2", c_drain);
        step("halted", c_halt);
        bus.ihit = 1'b0; bus.dREN_M = 1'b1; bus.branch_E = 1'b1;
        step("halt_sticky", c_halt);
        async_reset("reset_from_halt");

        bus.dREN_M = 1'b1; bus.dhit = 1'b0;
        step("mw_pre_rst_1", c_hold);
        step("mw_pre_rst_2", c_hold);
        async_reset("reset_from_mw");

        bus.load_E = 1'b1; bus.rt_E = 5'd9; bus.rs_D = 5'd9;
        step("perf_luse_1", c_lu);
        idle();
        step("perf_norm_1", c_norm);
        bus.load_E = 1'b1; bus.rt_E = 5'd10; bus.rt_D = 5'd10;
        step("perf_luse_2", c_lu);
        idle(); bus.branch_E = 1'b1;
        step("perf_branch", c_br);
        idle();
        step("perf_norm_2", c_norm);

`ifdef PIPELINE_PERF_EN
        n_checks++;
        assert (stall_cnt === 32'd2) else begin
            n_err++;
            $error("FAIL stall_cnt: observed=%0d expected=2", stall_cnt);
        end
        n_checks++;
        assert (flush_cnt === 32'd3) else begin
            n_err++;
            $error("FAIL flush_cnt: observed=%0d expected=3", flush_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
